// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared constants and types for the pipelined MIPS datapath.
//   XLEN        : datapath width in bits
//   INSTR_BYTES : byte stride between sequential instructions
//   NOP_WORD    : bubble instruction placed in a flushed or reset pipeline slot
//   RESET_PC    : program counter value loaded on reset
//   ifid_t      : contents of the IF/ID pipeline register
//   word_align  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int XLEN = 32;

  // Typed as a full-width vector so it adds directly to the PC without a cast.
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;  // fetched instruction word
    logic [XLEN-1:0] pc4;    // address of the fetched instruction plus 4
    logic            valid;  // slot holds a real fetched instruction
  } ifid_t;

  // Instructions are word aligned, so the low two address bits are forced to
  // zero wherever an externally supplied address enters the PC.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// -----------------------------------------------------------------------------
// ifid_pipe_reg
// IF/ID pipeline register with synchronous reset, flush and hold.
// Priority on each rising edge: rst > flush > hold > load.
//   clk   : pipeline clock
//   rst   : synchronous active-high reset, loads the bubble
//   hold  : keep the current contents
//   flush : load the bubble (overrides hold)
//   d     : next-state contents when loading
//   q     : current register contents
// -----------------------------------------------------------------------------
module ifid_pipe_reg #(
  parameter logic [31:0] NOP_WORD = mips_pipe_pkg::NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  mips_pipe_pkg::ifid_t  d,
  output mips_pipe_pkg::ifid_t  q
);
  import mips_pipe_pkg::*;

  // Bubble: no-op instruction, zero link address, marked not valid so that
  // downstream stages ignore it.
  localparam ifid_t BUBBLE = '{instr: NOP_WORD, pc4: '0, valid: 1'b0};

  ifid_t q_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= BUBBLE;
    end else if (flush) begin
      q_r <= BUBBLE;
    end else if (!hold) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage. Owns the PC, addresses instruction memory and fills
// the IF/ID pipeline register feeding the decode stage.
//   clk          : pipeline clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   stall        : hold PC, IF/ID and fetch counter this cycle
//   redirect     : taken branch/jump from ID; load redirect_pc, flush IF/ID
//   redirect_pc  : absolute target address from ID
//   imem_addr    : byte address to instruction memory (combinational pc copy)
//   imem_instr   : instruction word returned combinationally for imem_addr
//   pc           : current PC register
//   ifid_instr   : IF/ID instruction
//   ifid_pc4     : IF/ID PC+4, used by ID for branch target and link
//   ifid_valid   : IF/ID slot holds a real fetched instruction
//   fetch_count  : number of valid instructions written into IF/ID (mod 2^32)
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = mips_pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = mips_pipe_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);
  import mips_pipe_pkg::*;

  // Control semantics: there is no valid/ready handshake here. Each rising
  // edge takes exactly one action, chosen by priority
  //   rst > redirect > stall > normal fetch.
  // A redirect discards whatever imem_instr currently returns (it belongs to
  // the wrong path) and replaces it with a bubble, even if stall is also high.
  // A stall freezes the PC and IF/ID so the same address is re-presented and
  // the held instruction stays visible to decode.

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] fetch_count_q;
  logic        fetch_en;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  // Sequential next address; wraps modulo 2^32 with no flag.
  assign pc_plus4 = pc_q + INSTR_BYTES;

  // A real instruction enters IF/ID only when neither control is active.
  assign fetch_en = !redirect && !stall;

  always_comb begin
    pc_next = pc_plus4;
    if (redirect) begin
      pc_next = word_align(redirect_pc);
    end else if (stall) begin
      pc_next = pc_q;
    end
  end

  // RESET_PC is aligned as well so the PC never holds a misaligned address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (fetch_en) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  // The fetched word is tagged with the link address of its own PC.
  assign ifid_d = '{instr: imem_instr, pc4: pc_plus4, valid: 1'b1};

  ifid_pipe_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (redirect),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed vector table, a hand-written redirect sequence and randomized
// control traffic, all checked against values computed in this bench.
// Instruction memory returns 32'h2000_0000 | address.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .pc          (pc),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fetch_count (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 | a;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Architectural view: the PC, the single IF/ID slot and the fetch tally.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  task automatic model_edge(input logic r, input logic s, input logic d, input logic [31:0] t);
    if (r === 1'b1) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (d) begin
      m_pc = t & ~32'h3; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Inputs are applied #1 after an edge, the model is advanced, and outputs
  // are sampled #1 after the following edge.
  task automatic drive_edge(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    model_edge(r, s, d, t);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    chk({tag, "/pc"},        pc,          e_pc);
    chk({tag, "/imem_addr"}, imem_addr,   e_pc);
    chk({tag, "/instr"},     ifid_instr,  e_instr);
    chk({tag, "/pc4"},       ifid_pc4,    e_pc4);
    chk({tag, "/valid"},     {31'h0, ifid_valid}, {31'h0, e_valid});
    chk({tag, "/count"},     fetch_count, e_cnt);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    string       tag;
    logic        r, s, d;
    logic [31:0] t;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string tag, input logic r, input logic s, input logic d,
                              input logic [31:0] t, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid, input logic [31:0] e_cnt);
    vec_t v;
    v.tag = tag; v.r = r; v.s = s; v.d = d; v.t = t;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;

    //                tag        r     s     d     target        pc            instr         pc4           v     cnt
    vecs.push_back(mk("rst0",    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0));
    vecs.push_back(mk("rst1",    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0));
    vecs.push_back(mk("run1",    1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h2000_0000, 32'h4,       1'b1, 32'd1));
    vecs.push_back(mk("run2",    1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2000_0004, 32'h8,       1'b1, 32'd2));
    vecs.push_back(mk("run3",    1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h2000_0008, 32'hC,       1'b1, 32'd3));
    vecs.push_back(mk("rst2",    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0));
    vecs.push_back(mk("rst3",    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0));
    vecs.push_back(mk("pre1",    1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h2000_0000, 32'h4,       1'b1, 32'd1));
    vecs.push_back(mk("pre2",    1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h2000_0004, 32'h8,       1'b1, 32'd2));
    vecs.push_back(mk("stall1",  1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h2000_0004, 32'h8,       1'b1, 32'd2));
    vecs.push_back(mk("stall2",  1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h2000_0004, 32'h8,       1'b1, 32'd2));
    vecs.push_back(mk("stall3",  1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h2000_0004, 32'h8,       1'b1, 32'd2));
    vecs.push_back(mk("release", 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h2000_0008, 32'hC,       1'b1, 32'd3));
    vecs.push_back(mk("run4",    1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'h2000_000C, 32'h10,      1'b1, 32'd4));
    vecs.push_back(mk("redir",   1'b0, 1'b0, 1'b1, 32'h40,       32'h40,       32'h0,        32'h0,        1'b0, 32'd4));
    vecs.push_back(mk("target",  1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h2000_0040, 32'h44,      1'b1, 32'd5));
    vecs.push_back(mk("rd_stall",1'b0, 1'b1, 1'b1, 32'h103,      32'h100,      32'h0,        32'h0,        1'b0, 32'd5));
    vecs.push_back(mk("st_bub",  1'b0, 1'b1, 1'b0, 32'h0,        32'h100,      32'h0,        32'h0,        1'b0, 32'd5));
    vecs.push_back(mk("target2", 1'b0, 1'b0, 1'b0, 32'h0,        32'h104,      32'h2000_0100, 32'h104,     1'b1, 32'd6));
    vecs.push_back(mk("wrap_rd", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,        1'b0, 32'd6));
    vecs.push_back(mk("wrap",    1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       1'b1, 32'd7));
    vecs.push_back(mk("post",    1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h2000_0000, 32'h4,       1'b1, 32'd8));
    vecs.push_back(mk("rst_mid", 1'b1, 1'b1, 1'b1, 32'h55,       32'h0,        32'h0,        32'h0,        1'b0, 32'd0));
    vecs.push_back(mk("rst_x",   1'b1, 1'bx, 1'bx, 32'hx,        32'h0,        32'h0,        32'h0,        1'b0, 32'd0));
    vecs.push_back(mk("boot",    1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h2000_0000, 32'h4,       1'b1, 32'd1));

    foreach (vecs[i]) begin
      drive_edge(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].t);
      chk_all(vecs[i].tag, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
              vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Back-to-back redirects: the second target wins and the counter stays put.
    drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
    chk_all("b2b_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    drive_edge(1'b0, 1'b0, 1'b1, 32'h200);
    chk_all("b2b_rd1", 32'h200, 32'h0, 32'h0, 1'b0, 32'd0);
    drive_edge(1'b0, 1'b0, 1'b1, 32'h302);
    chk_all("b2b_rd2", 32'h300, 32'h0, 32'h0, 1'b0, 32'd0);
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    chk_all("b2b_run", 32'h304, 32'h2000_0300, 32'h304, 1'b1, 32'd1);

    // Randomized control traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      d = ($urandom_range(0, 99) < 12);
      t = $urandom();
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      drive_edge(r, s, d, t);
      chk_all("rand", m_pc, m_instr, m_pc4, m_valid, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against the run never reaching its end.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS datapath; sits directly upstream of the decode stage (register file read, sign extension, branch compare).
- Owns the program counter and drives the instruction memory address.
- Captures the returned instruction word and PC+4 into the IF/ID pipeline register.
- Honours stall (load-use hold) and redirect (taken branch/jump resolved in ID, which flushes the fetched slot).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, bubble instruction inserted into IF/ID on flush or reset.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
stall  input  1  hold PC and IF/ID contents this cycle.
redirect  input  1  taken branch/jump from ID; load redirect_pc and flush IF/ID.
redirect_pc  input  32  absolute target address from ID.
imem_addr  output  32  byte address to instruction memory; combinational copy of pc.
imem_instr  input  32  instruction word returned combinationally for imem_addr.
pc  output  32  current PC register.
ifid_instr  output  32  IF/ID instruction register.
ifid_pc4  output  32  IF/ID PC+4 register, used by ID for branch target and link.
ifid_valid  output  1  IF/ID slot holds a real fetched instruction.
fetch_count  output  32  number of instructions written into IF/ID with valid=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. No asynchronous reset path.
- State at reset, applied at the first rising edge with rst=1:
  - pc=RESET_PC
  - ifid_instr=NOP_WORD
  - ifid_pc4=0
  - ifid_valid=0
  - fetch_count=0
- imem_addr = pc at all times, with zero cycles of latency. pc[1:0] is always 2'b00.
- Priority on each rising edge, highest first: rst > redirect > stall > normal.
- Normal (all controls low):
  - pc <= pc+4
  - ifid_instr <= imem_instr
  - ifid_pc4 <= pc+4
  - ifid_valid <= 1
  - fetch_count <= fetch_count+1
- Stall: pc, ifid_instr, ifid_pc4, ifid_valid and fetch_count all hold. imem_addr stays constant.
- Redirect (overrides stall):
  - pc <= {redirect_pc[31:2],2'b00}
  - ifid_instr <= NOP_WORD
  - ifid_pc4 <= 0
  - ifid_valid <= 0
  - fetch_count holds
  - The wrong-path instruction currently on imem_instr is discarded.
- Latency: an instruction fetched at PC X appears on ifid_instr one edge after pc==X, provided there is no stall or redirect on that edge.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag. fetch_count also wraps modulo 2^32.
- After reset deasserts, the first edge latches the instruction at RESET_PC. ifid_valid goes high one edge after reset release.
- Reset mid-stall or mid-redirect: rst wins; all state takes its reset values on that edge.
- X on stall or redirect while rst=1 has no effect.

Decomposition:
- Shared package `mips_pipe_pkg`:
  - constants XLEN=32, INSTR_BYTES=4, NOP_WORD, RESET_PC
  - typedef `ifid_t` {instr, pc4, valid}
- One sub-module `ifid_pipe_reg`: IF/ID register with load, flush and synchronous reset. Inputs are the next-state values, flush and hold; output is `ifid_t`.
- PC register, incrementer, redirect mux and counter stay in the top.

Test Plan:
- Reset then run: rst high 2 cycles, imem returns 32'h2000_0000|addr. After release, edges 1-3 give ifid_instr=32'h2000_0000, 2000_0004, 2000_0008; ifid_pc4=4, 8, 12; pc=12; fetch_count=3.
- Stall: at pc=8, assert stall for 3 cycles. pc stays 8, imem_addr stays 8, ifid_instr holds 32'h2000_0004, fetch_count holds. The first edge after release gives ifid_instr=32'h2000_0008.
- Redirect: at pc=16, redirect=1 with redirect_pc=32'h40. Next edge: pc=32'h40, ifid_instr=0, ifid_valid=0, fetch_count unchanged. The following edge: ifid_instr=imem[0x40], ifid_pc4=32'h44.
- Simultaneous redirect+stall with redirect_pc=32'h103: pc=32'h100 (low bits cleared), IF/ID flushed.
- Wrap: redirect to 32'hFFFF_FFFC, then run one cycle. ifid_pc4=0 and pc=0.
- Mid-operation reset: rst asserted while stall=1 and redirect=1. Next edge: pc=RESET_PC, ifid_valid=0, fetch_count=0.
